// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
// A hit is answered in the same cycle. A miss starts a memory fetch that always runs to
// completion, then the filled word hits on the next cycle.
// Optional build macro: ICACHE_HALT_INVAL_EN. When it is defined, every clock edge seen in
// IDLE with halt=1 clears all valid bits.
module icache #(
  parameter int unsigned NFRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        halt,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  localparam int unsigned IDXW = $clog2(NFRAMES);
  localparam int unsigned TAGW = 30 - IDXW;

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e             state_q;
  logic [31:0]        addr_q;
  logic [NFRAMES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q  [NFRAMES];
  logic [31:0]        data_q [NFRAMES];

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic            hit;
  logic            fill;

  // Byte offset bits carry no information for word-aligned fetches.
  logic unused_offset;
  assign unused_offset = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDXW+1:2];
  assign req_tag  = imemaddr[31:IDXW+2];
  assign fill_idx = addr_q[IDXW+1:2];
  assign fill_tag = addr_q[31:IDXW+2];

  // Lookup and datapath-facing outputs. Hits are only served from IDLE.
  always_comb begin
    hit = 1'b0;
    if (imemREN && (state_q == StIdle) && valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
      hit = 1'b1;
    end
    ihit     = hit;
    imemload = hit ? data_q[req_idx] : 32'h0;
  end

  // Memory-side outputs follow the state register, so an async reset drops them at once.
  always_comb begin
    iREN  = (state_q == StFetch);
    iaddr = (state_q == StFetch) ? addr_q : 32'h0;
    fill  = (state_q == StFetch) && !iwait;
  end

  // Control FSM. It owns the state, the latched miss address and the valid bits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      addr_q  <= 32'h0;
      valid_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (imemREN && !hit && !halt) begin
            state_q <= StFetch;
            addr_q  <= imemaddr;
          end
`ifdef ICACHE_HALT_INVAL_EN
          if (halt) begin
            valid_q <= '0;
          end
`endif
        end
        StFetch: begin
          // Neither imemREN nor halt can abort a fetch that is in progress.
          if (!iwait) begin
            state_q           <= StIdle;
            valid_q[fill_idx] <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays are never reset. The valid bits gate every use of them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  localparam int unsigned NF = 16;
`ifdef ICACHE_HALT_INVAL_EN
  localparam bit INVAL = 1'b1;
`else
  localparam bit INVAL = 1'b0;
`endif

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        halt;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  icache #(.NFRAMES(NF)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .halt     (halt),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The model treats the cache as a map from frame number to the word address it holds,
  // plus a record of the one outstanding memory request.
  bit          m_valid [NF];
  logic [29:0] m_word  [NF];
  logic [31:0] m_data  [NF];
  bit          m_fetch = 1'b0;
  logic [31:0] m_addr  = 32'h0;

  function automatic int frame_of(input logic [31:0] a);
    return int'((a >> 2) % NF);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return imemREN && !m_fetch && m_valid[frame_of(a)] && (m_word[frame_of(a)] == a[31:2]);
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_fetch <= 1'b0;
      m_addr  <= 32'h0;
      for (int i = 0; i < NF; i++) m_valid[i] <= 1'b0;
    end else if (m_fetch) begin
      if (!iwait) begin
        m_valid[frame_of(m_addr)] <= 1'b1;
        m_word[frame_of(m_addr)]  <= m_addr[31:2];
        m_data[frame_of(m_addr)]  <= iload;
        m_fetch                   <= 1'b0;
      end
    end else begin
      if (imemREN && !model_hit(imemaddr) && !halt) begin
        m_fetch <= 1'b1;
        m_addr  <= imemaddr;
      end
      if (INVAL && halt) begin
        for (int i = 0; i < NF; i++) m_valid[i] <= 1'b0;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cmp ihit", {31'h0, ihit}, {31'h0, model_hit(imemaddr)});
      chk("cmp imemload", imemload, model_hit(imemaddr) ? m_data[frame_of(imemaddr)] : 32'h0);
      chk("cmp iREN", {31'h0, iREN}, {31'h0, m_fetch});
      chk("cmp iaddr", iaddr, m_fetch ? m_addr : 32'h0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Call this in an IDLE cycle while a missing address is presented. The task lets the
  // miss edge pass, then holds iwait high for 'waits' cycles before it returns data.
  task automatic run_fill(input string name, input logic [31:0] exp_addr, input int waits,
                          input logic [31:0] data);
    int nren = 0;
    int bad  = 0;
    tick();
    for (int i = 0; i < waits; i++) begin
      if (iREN) nren++;
      if (iaddr !== exp_addr || ihit) bad++;
      tick();
    end
    iwait = 1'b0;
    iload = data;
    if (iREN) nren++;
    if (iaddr !== exp_addr || ihit) bad++;
    tick();
    iwait = 1'b1;
    iload = 32'h0;
    chk({name, " iREN cycles"}, nren, waits + 1);
    chk({name, " iaddr/ihit during fetch"}, bad, 0);
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    halt     = 1'b0;
    iwait    = 1'b1;
    iload    = 32'h0;
    #8;
    chk("reset ihit", {31'h0, ihit}, 32'h0);
    chk("reset imemload", imemload, 32'h0);
    chk("reset iREN", {31'h0, iREN}, 32'h0);
    chk("reset iaddr", iaddr, 32'h0);
    #4;
    nRST   = 1'b1;
    chk_en = 1'b1;

    // Cold miss
    run_fill("cold", 32'h40, 3, 32'h2001000A);
    chk("cold hit", {31'h0, ihit}, 32'h1);
    chk("cold data", imemload, 32'h2001000A);

    // Conflict eviction: 0x80 maps to the same frame as 0x40
    imemaddr = 32'h80;
    #1;
    chk("conflict 0x80 miss", {31'h0, ihit}, 32'h0);
    run_fill("conflict", 32'h80, 2, 32'hDEADBEEF);
    chk("conflict hit data", imemload, 32'hDEADBEEF);
    imemaddr = 32'h40;
    #1;
    chk("conflict 0x40 evicted", {31'h0, ihit}, 32'h0);
    run_fill("conflict refill", 32'h40, 1, 32'h2001000A);

    // Redirect during a fetch, while imemREN drops and halt pulses
    imemaddr = 32'h100;
    tick();
    imemaddr = 32'h200;
    imemREN  = 1'b0;
    halt     = 1'b1;
    tick();
    chk("redirect iaddr held", iaddr, 32'h100);
    chk("redirect iREN held", {31'h0, iREN}, 32'h1);
    tick();
    chk("redirect iaddr held 2", iaddr, 32'h100);
    iwait   = 1'b0;
    iload   = 32'h11111111;
    halt    = 1'b0;
    imemREN = 1'b1;
    tick();
    iwait = 1'b1;
    iload = 32'h0;
    chk("redirect 0x200 miss", {31'h0, ihit}, 32'h0);
    imemaddr = 32'h100;
    #1;
    chk("redirect 0x100 filled", imemload, 32'h11111111);
    imemaddr = 32'h200;
    run_fill("redirect second", 32'h200, 0, 32'h22222222);
    chk("redirect 0x200 data", imemload, 32'h22222222);

    // Async reset in the middle of a fetch
    imemaddr = 32'h40;
    run_fill("pre-reset", 32'h40, 1, 32'h2001000A);
    imemaddr = 32'h44;
    tick();
    #2;
    nRST = 1'b0;
    #1;
    chk("async reset iREN", {31'h0, iREN}, 32'h0);
    chk("async reset iaddr", iaddr, 32'h0);
    tick();
    #2;
    nRST     = 1'b1;
    imemaddr = 32'h40;
    #1;
    chk("post-reset 0x40 miss", {31'h0, ihit}, 32'h0);
    run_fill("post-reset", 32'h40, 2, 32'h2001000A);
    chk("post-reset hit", {31'h0, ihit}, 32'h1);

    // imemREN low never hits
    imemREN = 1'b0;
    #1;
    chk("ren0 ihit", {31'h0, ihit}, 32'h0);
    chk("ren0 imemload", imemload, 32'h0);
    chk("ren0 iREN", {31'h0, iREN}, 32'h0);
    tick();
    tick();

    // Halt blocks fetches
    imemREN  = 1'b1;
    halt     = 1'b1;
    imemaddr = 32'h300;
    tick();
    chk("halt no fetch", {31'h0, iREN}, 32'h0);
    tick();
    chk("halt no fetch 2", {31'h0, iREN}, 32'h0);
    imemaddr = 32'h40;
    #1;
    chk("halt 0x40 hit", {31'h0, ihit}, {31'h0, !INVAL});
    tick();
    halt    = 1'b0;
    imemREN = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001: SHALL have parameters: NFRAMES, default 16, number of direct-mapped one-word frames (power of 2, 2..64).
REQ-002: SHALL have ports: CLK  input  1  rising-edge system clock.
REQ-003: nRST  input  1  reset, asynchronous, active-low.
REQ-004: imemREN  input  1  datapath instruction read request.
REQ-005: imemaddr  input  32  datapath instruction byte address, word-aligned.
REQ-006: ihit  output  1  requested word valid on imemload this cycle.
REQ-007: imemload  output  32  instruction word for imemaddr.
REQ-008: halt  input  1  datapath halted; sticky from datapath.
REQ-009: iREN  output  1  memory-side instruction read request.
REQ-010: iaddr  output  32  memory-side read address.
REQ-011: iload  input  32  memory-side read data.
REQ-012: iwait  input  1  memory busy; data on iload valid in a cycle with iREN=1 and iwait=0.

Function
REQ-013: SHALL split address as tag = imemaddr[31:IDXW+2], index = imemaddr[IDXW+1:2], IDXW = log2(NFRAMES); bits [1:0] ignored.
REQ-014: SHALL store per frame: valid bit, tag, 32-bit data.
REQ-015: Hit: imemREN=1, state IDLE, frame[index].valid=1, tag match -> ihit=1, imemload=frame data, same cycle (combinational, 0-cycle latency).
REQ-016: ihit SHALL be 0 whenever imemREN=0, on a miss, or in state FETCH.
REQ-017: imemload SHALL be 0 whenever ihit=0.
REQ-018: FSM states IDLE, FETCH only.
REQ-019: IDLE -> FETCH on imemREN=1, miss, halt=0; miss address latched into a 32-bit register at that edge.
REQ-020: In FETCH: iREN=1, iaddr=latched address; imemaddr changes ignored.
REQ-021: FETCH -> IDLE at edge where iwait=0; same edge writes iload, latched tag, valid=1 into latched index frame.
REQ-022: In IDLE: iREN=0, iaddr=0.
REQ-023: Fetch SHALL run to completion even if imemREN drops or halt rises mid-fetch; no abort.
REQ-024: Refilled word SHALL hit in the first IDLE cycle after fill (miss penalty = memory latency + 1 cycle).
REQ-025: Miss to valid frame with different tag SHALL overwrite it (conflict eviction).
REQ-026: halt=1 in IDLE SHALL block new fetches; hits still served.
REQ-027: No write path; frames only change by refill, reset, or REQ-032.

Reset
REQ-028: nRST low SHALL asynchronously force state IDLE, all valid bits 0, latched address 0.
REQ-029: During and after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-030: Reset mid-FETCH SHALL abandon the fetch; no frame written; iREN drops immediately.
REQ-031: Tag and data arrays need not be reset.

Configuration
REQ-032: Macro ICACHE_HALT_INVAL_EN defined -> at each edge in IDLE with halt=1, all valid bits cleared (hits return after halt deasserts only via refill); undefined -> halt has no effect on stored frames.

Verification
REQ-033: Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x2001000A -> iREN=1, iaddr=0x40 for 4 cycles, ihit=0; next cycle ihit=1, imemload=0x2001000A.
REQ-034: Conflict: after REQ-033, request 0x00000080 (same index, NFRAMES=16), fill 0xDEADBEEF -> then 0x40 misses again, iaddr=0x40.
REQ-035: Redirect mid-fetch: miss on 0x100, change imemaddr to 0x200 during FETCH -> iaddr stays 0x100 until fill; 0x100 fills; 0x200 then misses and fetches.
REQ-036: Async reset mid-FETCH: nRST low between edges -> iREN=0 immediately; after release, 0x40 misses (valid cleared).
REQ-037: Halt: halt=1, miss on 0x300 -> iREN stays 0; with ICACHE_HALT_INVAL_EN, previously filled 0x40 returns ihit=0 after one halted edge; without it ihit=1.
REQ-038: imemREN=0 with imemaddr=0x40 valid -> ihit=0, imemload=0, iREN=0.
